mmio_bus_ctrl: RTL and testbench

- Parametrised memory-mapped I/O bus controller between the processor's external memory port and NSLOT peripherals (RAM, audio, graphics, SPART, PS/2 and future devices).
- Successor to the fixed five-chip-select, zero-wait-state decoder.
- Adds:
  - configurable slot count and select field;
  - per-access acknowledge handshake with processor stall;
  - bus timeout;
  - error reporting for unmapped and timed-out accesses.

---
 rtl/mmio_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped I/O bus controller: decodes a slot from the processor address, stalls the CPU
// until the selected slot acknowledges or a timeout expires, and logs failed accesses.
module mmio_bus_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int NSLOT   = 8,
  parameter int SEL_HI  = 15,
  parameter int SEL_LO  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_stall,
  output logic                    cpu_err,
  output logic [NSLOT-1:0]        cs,
  output logic                    bus_read,
  output logic                    bus_write,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [DATA_W-1:0]       bus_wdata,
  input  logic [NSLOT*DATA_W-1:0] slot_rdata,
  input  logic [NSLOT-1:0]        slot_ack,
  output logic [ADDR_W-1:0]       err_addr,
  output logic [7:0]              err_cnt
);

  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   sel_q;
  logic                wr_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   err_addr_q;
  logic [7:0]          err_cnt_q;

  logic                req;
  logic                unmapped;
  logic                ack_sel;
  logic                timeout_hit;
  logic [DATA_W-1:0]   slot_data [NSLOT];

  assign req         = cpu_read | cpu_write;
  assign unmapped    = 32'(cpu_addr[SEL_HI:SEL_LO]) >= NSLOT;
  assign ack_sel     = slot_ack[sel_q];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      assign slot_data[gi] = slot_rdata[gi*DATA_W +: DATA_W];
      assign cs[gi]        = (state_q == ACCESS) && (sel_q == SLOT_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = unmapped ? DONE : ACCESS;
      ACCESS:  if (ack_sel || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The IDLE stall term is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    cpu_stall = 1'b0;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    cpu_err   = 1'b0;
    case (state_q)
      IDLE:    cpu_stall = req & rst;
      ACCESS: begin
        cpu_stall = 1'b1;
        bus_read  = ~wr_q;
        bus_write = wr_q;
      end
      DONE:    cpu_err = err_q;
      default: cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q       <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      req_addr_q  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          req_addr_q <= cpu_addr;
          err_q      <= unmapped;
          if (unmapped) begin
            rdata_q <= '1;
          end else begin
            bus_addr_q  <= cpu_addr;
            bus_wdata_q <= cpu_wdata;
            wr_q        <= cpu_write;
            sel_q       <= cpu_addr[SEL_LO +: SLOT_W];
            cnt_q       <= CNT_W'(1);
          end
        end
        ACCESS: begin
          if (ack_sel) begin
            rdata_q <= wr_q ? '0 : slot_data[sel_q];
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: if (err_q) begin
          err_addr_q <= req_addr_q;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: directed vector table, reset-abort sequence,
// randomized accesses against a transaction-level model, and error-counter saturation.
module tb_mmio_bus_ctrl;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int NSLOT   = 8;
  localparam int TIMEOUT = 15;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cpu_read, cpu_write;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [DATA_W-1:0]       cpu_wdata;
  logic [DATA_W-1:0]       cpu_rdata;
  logic                    cpu_stall, cpu_err;
  logic [NSLOT-1:0]        cs;
  logic                    bus_read, bus_write;
  logic [ADDR_W-1:0]       bus_addr;
  logic [DATA_W-1:0]       bus_wdata;
  logic [NSLOT*DATA_W-1:0] slot_rdata;
  logic [NSLOT-1:0]        slot_ack;
  logic [ADDR_W-1:0]       err_addr;
  logic [7:0]              err_cnt;

  mmio_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLOT(NSLOT), .SEL_HI(15), .SEL_LO(12),
                  .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .cs(cs), .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .slot_rdata(slot_rdata), .slot_ack(slot_ack),
    .err_addr(err_addr), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;
  logic [15:0] exp_err_addr = '0;

  typedef struct {
    bit          rd, wr;
    logic [15:0] addr, wdata;
    int          ack_at;      // ACCESS cycle on which the slot acks; 0 = never
    logic [15:0] ack_data;
    int          stray;       // slot acking every cycle regardless of selection; -1 = none
    logic [15:0] exp_rdata;
    bit          exp_err;
    int          exp_access;  // number of ACCESS cycles before DONE
    bit          chk_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Outcome of one access derived from the rules: unmapped -> immediate error, ack within the
  // timeout window -> success, otherwise timeout error with all-ones data.
  function automatic void model(input bit wr, input logic [15:0] addr, input int ack_at,
                                input logic [15:0] ack_data, output logic [15:0] rdata,
                                output bit err, output int acc, output bit chk_rd);
    int sel = int'(addr[15:12]);
    if (sel >= NSLOT) begin
      rdata = '0; err = 1'b1; acc = 0; chk_rd = 1'b0;
    end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
      rdata = wr ? 16'h0000 : ack_data; err = 1'b0; acc = ack_at; chk_rd = 1'b1;
    end else begin
      rdata = 16'hFFFF; err = 1'b1; acc = TIMEOUT; chk_rd = 1'b1;
    end
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int          sel = int'(v.addr[15:12]);
    int          done_at = -1;
    bit          bus_ok = 1'b1;
    logic [7:0]  exp_cs;
    exp_cs = (sel < NSLOT) ? 8'(1 << sel) : 8'h00;
    cpu_read = v.rd; cpu_write = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    #1;
    chk({tag, "_stall_c0"}, 32'(cpu_stall), 32'd1);
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      @(posedge clk); #1;
      slot_ack = '0;
      for (int s = 0; s < NSLOT; s++) slot_rdata[s*DATA_W +: DATA_W] = 16'($urandom);
      if (!cpu_stall) begin
        done_at = k;
      end else begin
        if (cs !== exp_cs || bus_read !== !v.wr || bus_write !== v.wr || bus_addr !== v.addr)
          bus_ok = 1'b0;
        if (v.wr && bus_wdata !== v.wdata) bus_ok = 1'b0;
        if (k == v.ack_at && sel < NSLOT) begin
          slot_ack[sel] = 1'b1;
          slot_rdata[sel*DATA_W +: DATA_W] = v.ack_data;
        end
        if (v.stray >= 0) slot_ack[v.stray] = 1'b1;
      end
    end
    cpu_read = 1'b0; cpu_write = 1'b0; slot_ack = '0;
    chk({tag, "_done_cycle"}, 32'(done_at), 32'(v.exp_access + 1));
    chk({tag, "_bus_during_access"}, 32'(bus_ok), 32'd1);
    chk({tag, "_err_pulse"}, 32'(cpu_err), 32'(v.exp_err));
    chk({tag, "_done_quiet"}, {22'd0, cs, bus_read, bus_write}, 32'd0);
    if (v.chk_rdata) chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(v.exp_rdata));
    if (v.exp_err) begin
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      exp_err_addr = v.addr;
    end
    @(posedge clk); #1;
    chk({tag, "_idle_err_low"}, 32'(cpu_err), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    chk({tag, "_err_addr"}, 32'(err_addr), 32'(exp_err_addr));
    if (v.chk_rdata) chk({tag, "_rdata_hold"}, 32'(cpu_rdata), 32'(v.exp_rdata));
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1, 0, 16'h2004, 16'h0000,  1, 16'hBEEF, -1, 16'hBEEF, 0,  1, 1};
    vecs[1] = '{0, 1, 16'h0010, 16'h1234,  4, 16'h5555, -1, 16'h0000, 0,  4, 1};
    vecs[2] = '{1, 0, 16'h5123, 16'h0000,  0, 16'h0000, -1, 16'hFFFF, 1, 15, 1};
    vecs[3] = '{1, 0, 16'hA000, 16'h0000,  0, 16'h0000, -1, 16'h0000, 1,  0, 0};
    vecs[4] = '{1, 0, 16'h1ABC, 16'h0000, 15, 16'h0F0F,  3, 16'h0F0F, 0, 15, 1};
    vecs[5] = '{1, 0, 16'h3000, 16'h0000, 16, 16'h7777, -1, 16'hFFFF, 1, 15, 1};
    vecs[6] = '{1, 1, 16'h7042, 16'hCAFE,  2, 16'h9999, -1, 16'h0000, 0,  2, 1};

    rst = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    slot_rdata = '0; slot_ack = '0;
    #3;
    chk("reset_outputs", {cpu_rdata, 8'd0, cs},       32'd0);
    chk("reset_ctl", {28'd0, cpu_stall, cpu_err, bus_read, bus_write}, 32'd0);
    chk("reset_err", {8'd0, err_cnt, err_addr},       32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Abort an access with reset while the request is still held.
    cpu_read = 1'b1; cpu_addr = 16'h1000;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_cs_before", 32'(cs), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("abort_cs",    32'(cs), 32'd0);
    chk("abort_read",  32'(bus_read), 32'd0);
    chk("abort_stall", 32'(cpu_stall), 32'd0);
    cpu_read = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    chk("abort_idle", {23'd0, cs, cpu_stall}, 32'd0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      int op = int'($urandom_range(0, 2));
      v.rd = (op != 1); v.wr = (op != 0);
      v.addr = 16'($urandom); v.wdata = 16'($urandom);
      v.ack_at = int'($urandom_range(0, TIMEOUT + 3));
      v.ack_data = 16'($urandom);
      v.stray = ($urandom_range(0, 3) == 0) ? ((int'(v.addr[15:12]) + 1) % NSLOT) : -1;
      model(v.wr, v.addr, v.ack_at, v.ack_data, v.exp_rdata, v.exp_err, v.exp_access,
            v.chk_rdata);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 300; i++) begin
      v = '{1, 0, 16'hA000 | 16'($urandom_range(0, 16'h5FFF)), 16'h0, 0, 16'h0, -1,
            16'h0, 1, 0, 0};
      run_txn(v, $sformatf("unm%0d", i));
    end
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
